// File: rtl/rotary_knob_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_knob_decoder_pkg
//  Brief    : Shared constants and helpers for the rotary encoder decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package rotary_knob_decoder_pkg;

    // 100 us of filtering at a 50 MHz system clock
    localparam int          c_FILTER_CYCLES_DEFAULT = 5000;

    localparam logic        c_DIR_LEFT  = 1'b1;
    localparam logic        c_DIR_RIGHT = 1'b0;

    localparam int          c_POS_W     = 3;
    localparam int          c_NUM_POS   = 8;
    localparam logic [7:0]  c_LED_RESET = 8'b0000_0001;

    // One-hot LED pattern for a position
    function automatic logic [7:0] pos_to_led(input logic [c_POS_W-1:0] pos);
        return c_LED_RESET << pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotary_knob_decoder_deglitch.sv
`default_nettype none
// ============================================================================
//  Module   : input_deglitch
//  Brief    : Two-flop synchroniser followed by a persistence filter. The
//             filtered output only follows the synchronised input once the
//             two have differed for FILTER_CYCLES consecutive cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module input_deglitch
    import rotary_knob_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = c_FILTER_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int                CNT_W     = $clog2(FILTER_CYCLES);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise the raw input, then count how long it disagrees with the filtered value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_filt) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_filt <= r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end else begin
                // any agreeing cycle throws away a partial count
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_filt;

endmodule
`default_nettype wire

// File: rtl/rotary_knob_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_knob_decoder
//  Brief    : Quadrature rotary encoder + push switch decoder. Deglitches the
//             raw inputs, turns filtered rising edges of A into step events
//             (direction from B), keeps a wrapping 3-bit position and drives
//             it as a one-hot LED pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module rotary_knob_decoder
    import rotary_knob_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES = c_FILTER_CYCLES_DEFAULT,
    parameter int NUM_POS       = c_NUM_POS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rot_a,
    input  logic                rot_b,
    input  logic                rot_press,
    output logic                rot_event,
    output logic                rot_left,
    output logic                press_pulse,
    output logic [c_POS_W-1:0]  pos,
    output logic [NUM_POS-1:0]  led
);

    logic               w_filt_a;
    logic               w_filt_b;
    logic               w_filt_press;
    logic               w_step;
    logic               w_dir;
    logic               w_press_rise;
    logic [c_POS_W-1:0] w_pos_next;

    logic               r_filt_a_d;
    logic               r_filt_press_d;
    logic               r_event;
    logic               r_left;
    logic               r_press_pulse;
    logic [c_POS_W-1:0] r_pos;
    logic [NUM_POS-1:0] r_led;

    input_deglitch #(.FILTER_CYCLES(FILTER_CYCLES)) u_deglitch_a (
        .clk  (clk),
        .rst  (rst),
        .din  (rot_a),
        .dout (w_filt_a)
    );

    input_deglitch #(.FILTER_CYCLES(FILTER_CYCLES)) u_deglitch_b (
        .clk  (clk),
        .rst  (rst),
        .din  (rot_b),
        .dout (w_filt_b)
    );

    input_deglitch #(.FILTER_CYCLES(FILTER_CYCLES)) u_deglitch_press (
        .clk  (clk),
        .rst  (rst),
        .din  (rot_press),
        .dout (w_filt_press)
    );

    // Only the rising edge of filtered A is a detent step; B just gives the direction
    assign w_step       = w_filt_a & ~r_filt_a_d;
    assign w_dir        = w_filt_b ? c_DIR_LEFT : c_DIR_RIGHT;
    assign w_press_rise = w_filt_press & ~r_filt_press_d;

    // Next position: a press wins over a simultaneous step, wrap is natural 3-bit overflow
    always_comb begin
        w_pos_next = r_pos;
        if (w_press_rise) begin
            w_pos_next = '0;
        end else if (w_step) begin
            if (w_dir == c_DIR_LEFT) begin
                w_pos_next = r_pos - 1'b1;
            end else begin
                w_pos_next = r_pos + 1'b1;
            end
        end
    end

    // Edge-detect history plus registered event, position and LED outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_a_d     <= 1'b0;
            r_filt_press_d <= 1'b0;
            r_event        <= 1'b0;
            r_left         <= 1'b0;
            r_press_pulse  <= 1'b0;
            r_pos          <= '0;
            r_led          <= c_LED_RESET;
        end else begin
            r_filt_a_d     <= w_filt_a;
            r_filt_press_d <= w_filt_press;
            r_event        <= w_step;
            r_left         <= w_step & w_dir;
            r_press_pulse  <= w_press_rise;
            r_pos          <= w_pos_next;
            r_led          <= pos_to_led(w_pos_next);
        end
    end

    assign rot_event   = r_event;
    assign rot_left    = r_left;
    assign press_pulse = r_press_pulse;
    assign pos         = r_pos;
    assign led         = r_led;

endmodule
`default_nettype wire

// File: tb/tb_rotary_knob_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotary_knob_decoder
//  Brief    : Scoreboard bench for rotary_knob_decoder with FILTER_CYCLES=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotary_knob_decoder;

    localparam int c_FC  = 4;
    localparam int c_LAT = c_FC + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rot_a;
    logic       rot_b;
    logic       rot_press;
    logic       rot_event;
    logic       rot_left;
    logic       press_pulse;
    logic [2:0] pos;
    logic [7:0] led;

    typedef struct {
        int         cyc;
        logic       ev;
        logic       left;
        logic       pr;
        logic [2:0] pos;
        logic [7:0] led;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [2:0] exp_pos = 3'd0;

    rotary_knob_decoder #(.FILTER_CYCLES(c_FC), .NUM_POS(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rot_a       (rot_a),
        .rot_b       (rot_b),
        .rot_press   (rot_press),
        .rot_event   (rot_event),
        .rot_left    (rot_left),
        .press_pulse (press_pulse),
        .pos         (pos),
        .led         (led)
    );

    always #5 clk = ~clk;

    // Count rising edges; read on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] onehot(input logic [2:0] p);
        logic [7:0] one;
        one = 8'd1;
        return one << p;
    endfunction

    // Scoreboard monitor: every pulse must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (rot_event === 1'b1 || press_pulse === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, rot_event, press_pulse}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("latency",     cyc,         e.cyc);
                chk("rot_event",   rot_event,   e.ev);
                chk("rot_left",    rot_left,    e.left);
                chk("press_pulse", press_pulse, e.pr);
                chk("pos",         pos,         e.pos);
                chk("led",         led,         e.led);
            end
        end else begin
            if (q.size() != 0 && cyc > q[0].cyc) begin
                chk("missing_pulse", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            if (rot_left !== 1'b0) chk("left_idle", rot_left, 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic ev, input logic left, input logic pr);
        exp_t e;
        e.cyc  = cyc + c_LAT;
        e.ev   = ev;
        e.left = left;
        e.pr   = pr;
        e.pos  = exp_pos;
        e.led  = onehot(exp_pos);
        q.push_back(e);
    endtask

    task automatic step(input logic left);
        rot_b = left;
        tick(10);
        rot_a = 1'b1;
        exp_pos = left ? exp_pos - 3'd1 : exp_pos + 3'd1;
        push(1'b1, left, 1'b0);
        tick(15);
        rot_a = 1'b0;
        tick(12);
        rot_b = 1'b0;
        tick(10);
    endtask

    task automatic press();
        rot_press = 1'b1;
        exp_pos = 3'd0;
        push(1'b0, 1'b0, 1'b1);
        tick(15);
        rot_press = 1'b0;
        tick(12);
    endtask

    initial begin
        rst = 1'b1; rot_a = 1'b0; rot_b = 1'b0; rot_press = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset_pos",   pos,         3'd0);
        chk("reset_led",   led,         8'h01);
        chk("reset_event", rot_event,   1'b0);
        chk("reset_press", press_pulse, 1'b0);
        tick(50);
        chk("idle_pos", pos, 3'd0);
        chk("idle_led", led, 8'h01);

        // single right step, held, then A falls
        step(1'b0);
        chk("step1_pos", pos, 3'd1);
        chk("step1_led", led, 8'h02);

        // glitch of FILTER_CYCLES-1 cycles is rejected
        rot_a = 1'b1;
        tick(c_FC - 1);
        rot_a = 1'b0;
        tick(20);
        chk("glitch_pos", pos, 3'd1);

        // pulse of exactly FILTER_CYCLES cycles is accepted
        rot_a = 1'b1;
        exp_pos = exp_pos + 3'd1;
        push(1'b1, 1'b0, 1'b0);
        tick(c_FC);
        rot_a = 1'b0;
        tick(20);
        chk("minpulse_pos", pos, 3'd2);

        // press back to 0, eight right steps wrap, then one left step
        press();
        chk("press_pos", pos, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("wrap_pos", pos, 3'd0);
        chk("wrap_led", led, 8'h01);
        step(1'b1);
        chk("left_pos", pos, 3'd7);
        chk("left_led", led, 8'h80);

        // go to 5, then press and A rise accepted on the same cycle
        press();
        for (int i = 0; i < 5; i++) step(1'b0);
        chk("five_pos", pos, 3'd5);
        rot_a = 1'b1;
        rot_press = 1'b1;
        exp_pos = 3'd0;
        push(1'b1, 1'b0, 1'b1);
        tick(15);
        rot_a = 1'b0;
        rot_press = 1'b0;
        tick(15);
        chk("combo_pos", pos, 3'd0);
        chk("combo_led", led, 8'h01);

        // take a step so reset has something to clear
        step(1'b0);
        chk("pre_rst_pos", pos, 3'd1);

        // reset mid-filter with A held high
        rot_a = 1'b1;
        tick(2 + 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_pos = 3'd0;
        chk("midrst_pos", pos, 3'd0);
        exp_pos = 3'd1;
        push(1'b1, 1'b0, 1'b0);
        tick(20);
        rot_a = 1'b0;
        tick(20);
        chk("post_rst_pos", pos, 3'd1);
        chk("post_rst_led", led, 8'h02);

        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
